// File: rtl/uart_rx.sv
// Oversampling UART receiver: 1 start, DATA_WIDTH data bits (LSB first), optional parity, 1 stop.
// Each bit is the 2-of-3 majority of samples taken around mid-cell.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state, next_state;
  logic [5:0]              edge_cnt;
  logic [5:0]              presc_q;
  logic [5:0]              presc_dec;
  logic [5:0]              half;
  logic [BW-1:0]           bit_cnt;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    par_bad;
  logic [2:0]              samp;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    cell_end;
  logic                    majority;
  logic                    start_det;
  logic                    shift_en;
  logic                    par_chk;
  logic                    frame_end;

  // Unsupported ratios fall back to 8x oversampling.
  always_comb begin
    case (PRESCALE)
      6'd16:   presc_dec = 6'd16;
      6'd32:   presc_dec = 6'd32;
      default: presc_dec = 6'd8;
    endcase
  end

  assign half     = {1'b0, presc_q[5:1]};
  assign cell_end = (edge_cnt == presc_q - 6'd1);
  assign majority = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!RX_IN) next_state = START;
      START:   if (cell_end) next_state = majority ? IDLE : DATA;
      DATA:    if (cell_end && bit_cnt == LAST_BIT) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (cell_end) next_state = STOP;
      STOP:    if (cell_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    start_det = (state == IDLE) && !RX_IN;
    shift_en  = (state == DATA) && cell_end;
    par_chk   = (state == PARITY) && cell_end;
    frame_end = (state == STOP) && cell_end;
  end

  // The start-detect cycle is edge 0 of the start cell, so counting resumes at 1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt  <= '0;
      presc_q   <= 6'd8;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      samp      <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bad   <= 1'b0;
    end else begin
      if (start_det) begin
        edge_cnt  <= 6'd1;
        presc_q   <= presc_dec;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        bit_cnt   <= '0;
        par_bad   <= 1'b0;
      end else if (state != IDLE) begin
        edge_cnt <= cell_end ? 6'd0 : edge_cnt + 6'd1;
      end else begin
        edge_cnt <= '0;
      end
      if (state != IDLE) begin
        if (edge_cnt == half - 6'd1) samp[0] <= RX_IN;
        if (edge_cnt == half)        samp[1] <= RX_IN;
        if (edge_cnt == half + 6'd1) samp[2] <= RX_IN;
      end
      if (shift_en) begin
        shift_reg <= {majority, shift_reg[DATA_WIDTH-1:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (par_chk) par_bad <= (majority != (^shift_reg ^ par_typ_q));
    end
  end

  // Completion pulses land the cycle after the stop cell ends.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (frame_end) begin
        if (par_bad || !majority) begin
          PAR_ERR <= par_bad;
          STP_ERR <= !majority;
        end else begin
          DATA_VALID <= 1'b1;
          P_DATA     <= shift_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level model predicts pulse cycle and contents;
// a per-cycle compare process checks every output against it.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit checking = 1'b0;
  logic [7:0] modelData = 8'h00;

  typedef struct {
    int         at;
    logic       v;
    logic       pe;
    logic       se;
    logic [7:0] d;
  } ev_t;
  ev_t evq[$];

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int effPrescale(input logic [5:0] p);
    if (p == 6'd16) return 16;
    if (p == 6'd32) return 32;
    return 8;
  endfunction

  always @(negedge CLK) begin
    logic expV, expP, expS;
    ev_t ev;
    if (checking) begin
      expV = 1'b0; expP = 1'b0; expS = 1'b0;
      if (!RST) begin
        evq.delete();
        modelData = 8'h00;
      end else if (evq.size() > 0 && evq[0].at == cyc) begin
        ev = evq.pop_front();
        expV = ev.v; expP = ev.pe; expS = ev.se;
        if (ev.v) modelData = ev.d;
      end else if (evq.size() > 0 && evq[0].at < cyc) begin
        ev = evq.pop_front();
        checkOutput("event_missed", 32'(cyc), 32'(ev.at));
      end
      checkOutput("cmp_valid", 32'(DATA_VALID), 32'(expV));
      checkOutput("cmp_par_err", 32'(PAR_ERR), 32'(expP));
      checkOutput("cmp_stp_err", 32'(STP_ERR), 32'(expS));
      checkOutput("cmp_p_data", 32'(P_DATA), 32'(modelData));
    end
  end

  task automatic idleCycles(input int n);
    RX_IN = 1'b1;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Drives the first `cells` cells of a frame; a complete frame registers its expected outcome.
  // Frame-format inputs are disturbed after the start cell; they must have been latched.
  task automatic applyStimulus(input logic [7:0] data, input logic pBit, input logic stopBit,
                               input logic [5:0] presc, input logic pEn, input logic pTyp,
                               input int cells);
    int p, n, cnt, t0;
    logic [11:0] bits;
    logic expPar;
    ev_t ev;
    p = effPrescale(presc);
    n = pEn ? 11 : 10;
    cnt = (cells > n) ? n : cells;
    bits = 12'hFFF;
    bits[0] = 1'b0;
    bits[8:1] = data;
    if (pEn) begin bits[9] = pBit; bits[10] = stopBit; end
    else bits[9] = stopBit;
    PRESCALE = presc; PAR_EN = pEn; PAR_TYP = pTyp;
    t0 = cyc;
    if (cnt == n) begin
      expPar = ^data ^ pTyp;
      ev.at = t0 + n * p;
      ev.pe = pEn && (pBit != expPar);
      ev.se = !stopBit;
      ev.v  = !ev.pe && !ev.se;
      ev.d  = data;
      evq.push_back(ev);
    end
    for (int c = 0; c < cnt; c++) begin
      RX_IN = bits[c];
      if (c == 1) begin
        PRESCALE = (p == 8) ? 6'd32 : 6'd8;
        PAR_EN = ~pEn;
        PAR_TYP = ~pTyp;
      end
      repeat (p) begin @(posedge CLK); #1; end
    end
  endtask

  initial begin
    RST = 1'b0; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_p_data", 32'(P_DATA), 32'h00);
    checkOutput("reset_valid", 32'(DATA_VALID), 32'h0);
    checkOutput("reset_errs", 32'({PAR_ERR, STP_ERR}), 32'h0);
    RST = 1'b1;
    checking = 1'b1;
    idleCycles(5);

    // 8x, even parity, 0xA5: pulse at t0+88
    applyStimulus(8'hA5, 1'b0, 1'b1, 6'd8, 1'b1, 1'b0, 99);
    checkOutput("t1_valid", 32'(DATA_VALID), 32'h1);
    checkOutput("t1_p_data", 32'(P_DATA), 32'hA5);
    checkOutput("t1_errs", 32'({PAR_ERR, STP_ERR}), 32'h0);
    idleCycles(7);

    // 16x back-to-back, pulses at t0+160 and t0+320
    applyStimulus(8'h3C, 1'b0, 1'b1, 6'd16, 1'b0, 1'b0, 99);
    checkOutput("t2a_valid", 32'(DATA_VALID), 32'h1);
    checkOutput("t2a_p_data", 32'(P_DATA), 32'h3C);
    applyStimulus(8'hC3, 1'b0, 1'b1, 6'd16, 1'b0, 1'b0, 99);
    checkOutput("t2b_valid", 32'(DATA_VALID), 32'h1);
    checkOutput("t2b_p_data", 32'(P_DATA), 32'hC3);
    idleCycles(9);

    // 32x odd parity, 0x01 with wrong parity bit 1: PAR_ERR at t0+352
    applyStimulus(8'h01, 1'b1, 1'b1, 6'd32, 1'b1, 1'b1, 99);
    checkOutput("t3_par_err", 32'(PAR_ERR), 32'h1);
    checkOutput("t3_valid", 32'(DATA_VALID), 32'h0);
    checkOutput("t3_p_data", 32'(P_DATA), 32'hC3);
    idleCycles(4);

    // 8x, stop bit low: STP_ERR at t0+80, then a good frame
    applyStimulus(8'h55, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0, 99);
    checkOutput("t4_stp_err", 32'(STP_ERR), 32'h1);
    checkOutput("t4_par_err", 32'(PAR_ERR), 32'h0);
    checkOutput("t4_p_data", 32'(P_DATA), 32'hC3);
    idleCycles(3);
    applyStimulus(8'h66, 1'b0, 1'b1, 6'd8, 1'b0, 1'b0, 99);
    checkOutput("t4b_valid", 32'(DATA_VALID), 32'h1);
    checkOutput("t4b_p_data", 32'(P_DATA), 32'h66);
    idleCycles(5);

    // Both errors together: 16x even parity, 0x0F, parity 1, stop 0
    applyStimulus(8'h0F, 1'b1, 1'b0, 6'd16, 1'b1, 1'b0, 99);
    checkOutput("t5_both_errs", 32'({PAR_ERR, STP_ERR}), 32'h3);
    checkOutput("t5_p_data", 32'(P_DATA), 32'h66);
    idleCycles(5);

    // Unsupported prescale 10 behaves as 8x
    applyStimulus(8'h3A, 1'b0, 1'b1, 6'd10, 1'b1, 1'b0, 99);
    checkOutput("t6_valid", 32'(DATA_VALID), 32'h1);
    checkOutput("t6_p_data", 32'(P_DATA), 32'h3A);
    idleCycles(5);

    // Start glitch: low 3 cycles, no pulses, P_DATA unchanged
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    idleCycles(20);
    checkOutput("t7_p_data", 32'(P_DATA), 32'h3A);

    // Reset during data bit 4 of 0xFF, then 0x12 decodes
    applyStimulus(8'hFF, 1'b0, 1'b1, 6'd8, 1'b0, 1'b0, 5);
    RX_IN = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end
    RST = 1'b0;
    #1;
    checkOutput("t8_rst_p_data", 32'(P_DATA), 32'h00);
    checkOutput("t8_rst_pulses", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    idleCycles(10);
    applyStimulus(8'h12, 1'b0, 1'b1, 6'd8, 1'b0, 1'b0, 99);
    checkOutput("t8_valid", 32'(DATA_VALID), 32'h1);
    checkOutput("t8_p_data", 32'(P_DATA), 32'h12);
    idleCycles(10);

    checkOutput("events_drained", 32'(evq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
